dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/mem_pkg.sv | 33 +++
 rtl/rd_track.sv | 54 +++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory arbiter slice.
//   - requester identifiers (M0 = 0, M1 = 1)
//   - default address/data widths of the data-memory port
//   - round-robin winner selection helper
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_e;

    // Winner among the active requesters; only meaningful when r0 | r1.
    // Under contention the requester named by prio wins.
    function automatic req_id_e rr_winner(input logic r0, input logic r1,
                                          input req_id_e prio);
        req_id_e win;
        if (r0 && r1) begin
            win = prio;
        end else if (r1) begin
            win = M1;
        end else begin
            win = M0;
        end
        return win;
    endfunction

endpackage

// File: rtl/rd_track.sv
// -----------------------------------------------------------------------------
// rd_track
// Read-return tracker: an RD_LAT-deep shift register of {valid, owner}.
// A read issued in cycle t appears at the output stage in cycle t+RD_LAT,
// which is when the memory presents its data.
// Ports:
//   clock       system clock, rising edge
//   reset_btn   asynchronous active-low reset, clears all stages
//   issue_vld   a read is issued this cycle
//   issue_owner requester that issued the read
//   ret_vld     read data for the oldest tracked read is on mem_data_out now
//   ret_owner   requester that read belongs to
// -----------------------------------------------------------------------------
module rd_track
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1    // 1..4
) (
    input  logic    clock,
    input  logic    reset_btn,
    input  logic    issue_vld,
    input  req_id_e issue_owner,
    output logic    ret_vld,
    output req_id_e ret_owner
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] owner_q, owner_d;

    always_comb begin
        vld_d      = vld_q;
        owner_d    = owner_q;
        vld_d[0]   = issue_vld;
        owner_d[0] = issue_owner;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            vld_q   <= '0;
            owner_q <= '0;
        end else begin
            vld_q   <= vld_d;
            owner_q <= owner_d;
        end
    end

    assign ret_vld   = vld_q[RD_LAT-1];
    assign ret_owner = req_id_e'(owner_q[RD_LAT-1]);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter in front of a single data-memory/MMIO port.
// One access is issued per cycle; the granted request drives the memory port
// combinationally in its grant cycle. Reads return RD_LAT cycles later and are
// routed back to the issuing requester.
// Ports:
//   clock, reset_btn          clock (rising edge), async active-low reset
//   mN_req/wren/addr/wdata    request from requester N (held until mN_gnt)
//   mN_gnt                    request N issued this cycle
//   mN_rvalid/mN_rdata        read return for requester N (rdata holds between)
//   mem_address/data_in/wren  shared memory port, all zero when idle
//   mem_data_out              read data from memory, valid RD_LAT after issue
// -----------------------------------------------------------------------------
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_btn,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wren,
    input  logic              m1_wren,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_data_out
);

    req_id_e           prio_q, prio_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              issue;
    req_id_e           issue_id;
    logic              ret_vld;
    req_id_e           ret_owner;

    // Grants are gated by reset_btn so nothing is issued while reset is held.
    always_comb begin
        issue       = reset_btn && (m0_req || m1_req);
        issue_id    = rr_winner(m0_req, m1_req, prio_q);
        m0_gnt      = issue && (issue_id == M0);
        m1_gnt      = issue && (issue_id == M1);
        mem_address = '0;
        mem_data_in = '0;
        mem_wren    = 1'b0;
        if (m0_gnt) begin
            mem_address = m0_addr;
            mem_data_in = m0_wdata;
            mem_wren    = m0_wren;
        end else if (m1_gnt) begin
            mem_address = m1_addr;
            mem_data_in = m1_wdata;
            mem_wren    = m1_wren;
        end
        // Pointer always moves away from whoever was just served.
        prio_d = prio_q;
        if (issue) begin
            prio_d = (issue_id == M0) ? M1 : M0;
        end
    end

    rd_track #(
        .RD_LAT (RD_LAT)
    ) u_rd_track (
        .clock       (clock),
        .reset_btn   (reset_btn),
        .issue_vld   (issue && !mem_wren),
        .issue_owner (issue_id),
        .ret_vld     (ret_vld),
        .ret_owner   (ret_owner)
    );

    // Return data passes straight through in the return cycle and is then
    // held in a per-requester register until the next return.
    always_comb begin
        m0_rvalid = ret_vld && (ret_owner == M0);
        m1_rvalid = ret_vld && (ret_owner == M1);
        m0_rdata  = m0_rvalid ? mem_data_out : rdata0_q;
        m1_rdata  = m1_rvalid ? mem_data_out : rdata1_q;
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            prio_q   <= M0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            prio_q   <= prio_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
